// File: rtl/bnn_fc_pkg.sv
// -----------------------------------------------------------------------------
// bnn_fc_pkg
// Shared types and constant helpers for the time-multiplexed binarized
// fully-connected layer (bnn_fc_sched and bnn_neuron_eval).
//   state_t   : scheduler states IDLE / RUN / DRAIN / DONE
//   ceil_div  : integer ceiling division, used for the weight-group count
//   pop_w     : signed width that holds 2*popcount and THRESHOLD+popcount
// -----------------------------------------------------------------------------
package bnn_fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // popcount needs $clog2(isize+1) bits; one more for the doubling and one
    // for the sign so a negative THRESHOLD still compares correctly.
    function automatic int pop_w(input int isize);
        return $clog2(isize + 1) + 2;
    endfunction

endpackage

// File: rtl/bnn_neuron_eval.sv
// -----------------------------------------------------------------------------
// bnn_neuron_eval
// Combinational evaluation of one binarized neuron:
//   x   = ~(act ^ w) & mask
//   out = 2*popcount(x) > THRESHOLD + popcount(mask)   (signed compare)
// Parameters: ISIZE (inputs per neuron), THRESHOLD (signed offset).
// Ports:
//   act     in  ISIZE  binary activations
//   w       in  ISIZE  binary weights
//   mask    in  ISIZE  per-weight valid mask (0 = weight ignored)
//   bit_out out 1      neuron output
// -----------------------------------------------------------------------------
module bnn_neuron_eval
    import bnn_fc_pkg::*;
#(
    parameter int ISIZE     = 81,
    parameter int THRESHOLD = 0
) (
    input  logic [ISIZE-1:0] act,
    input  logic [ISIZE-1:0] w,
    input  logic [ISIZE-1:0] mask,
    output logic             bit_out
);

    localparam int PW = pop_w(ISIZE);

    logic [ISIZE-1:0]     x;
    logic signed [PW-1:0] cnt;
    logic signed [PW-1:0] nv;
    logic signed [PW-1:0] lhs;
    logic signed [PW-1:0] rhs;

    always_comb begin
        x       = ~(act ^ w) & mask;
        cnt     = PW'($countones(x));
        nv      = PW'($countones(mask));
        lhs     = cnt <<< 1;
        rhs     = PW'(THRESHOLD) + nv;
        bit_out = (lhs > rhs);
    end

endmodule

// File: rtl/bnn_fc_sched.sv
// -----------------------------------------------------------------------------
// bnn_fc_sched
// Time-multiplexed scheduler/evaluator for one binarized fully-connected
// layer. Latches one activation vector, reads NGRP weight/mask words from a
// 1-cycle-latency weight memory (PAR neurons per word) and returns the
// LSIZE-bit result with a valid/ready handshake.
//
// Optional feature (macro BNN_FC_PERF_EN): saturating perf counters
// perf_infer (completed output handshakes) and perf_stall (DONE cycles
// with out_ready low).
//
// Ports:
//   clk         in   1          clock
//   rst         in   1          asynchronous reset, active-low
//   in_valid    in   1          activation vector offered
//   in_ready    out  1          high only in IDLE
//   in_act      in   ISIZE      binary activations
//   w_rd_en     out  1          weight memory read strobe (RUN only)
//   w_addr      out  AW         weight group index
//   w_data      in   PAR*ISIZE  weights, neuron p at [p*ISIZE +: ISIZE]
//   w_mask      in   PAR*ISIZE  weight valid mask, same layout as w_data
//   out_valid   out  1          result available (DONE)
//   out_ready   in   1          consumer accepts the result
//   out_bits    out  LSIZE      neuron outputs, bit n = neuron n
//   perf_infer  out  16         (BNN_FC_PERF_EN only) handshake count
//   perf_stall  out  16         (BNN_FC_PERF_EN only) DONE stall cycles
//   busy        out  1          state != IDLE
// -----------------------------------------------------------------------------
module bnn_fc_sched
    import bnn_fc_pkg::*;
#(
    parameter int ISIZE     = 81,
    parameter int LSIZE     = 10,
    parameter int PAR       = 2,
    parameter int THRESHOLD = 0,
    localparam int NGRP     = ceil_div(LSIZE, PAR),
    localparam int AW       = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ISIZE-1:0]     in_act,
    output logic                 w_rd_en,
    output logic [AW-1:0]        w_addr,
    input  logic [PAR*ISIZE-1:0] w_data,
    input  logic [PAR*ISIZE-1:0] w_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LSIZE-1:0]     out_bits,
`ifdef BNN_FC_PERF_EN
    output logic [15:0]          perf_infer,
    output logic [15:0]          perf_stall,
`endif
    output logic                 busy
);

    state_t           state;
    state_t           state_nxt;
    logic [ISIZE-1:0] act_q;
    logic [AW-1:0]    issue_grp;   // group address issued this cycle
    logic             eval_v;      // w_data/w_mask carry a group this cycle
    logic [AW-1:0]    eval_grp;    // which group w_data/w_mask belong to
    logic             last_issue;
    logic             accept;
    logic [PAR-1:0]   grp_bits;
    logic [LSIZE-1:0] bits_nxt;

    assign last_issue = (issue_grp == AW'(NGRP - 1));
    assign accept     = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Evaluate stage: PAR neurons share the latched activation vector.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < PAR; p++) begin : g_neuron
        bnn_neuron_eval #(
            .ISIZE     (ISIZE),
            .THRESHOLD (THRESHOLD)
        ) u_eval (
            .act     (act_q),
            .w       (w_data[p*ISIZE +: ISIZE]),
            .mask    (w_mask[p*ISIZE +: ISIZE]),
            .bit_out (grp_bits[p])
        );
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs. Read strobe and handshakes are decoded
    // from the state so an asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        w_rd_en   = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                w_rd_en = 1'b1;
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                // last group's data is on w_data now
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign w_addr = w_rd_en ? issue_grp : '0;
    assign busy   = (state != IDLE);

    // ------------------------------------------------------------------
    // Result merge: only neurons n < LSIZE exist, so unused slices of the
    // last group never reach out_bits.
    // ------------------------------------------------------------------
    always_comb begin
        bits_nxt = out_bits;
        for (int n = 0; n < LSIZE; n++) begin
            if (eval_v && (eval_grp == AW'(n / PAR))) begin
                bits_nxt[n] = grp_bits[n % PAR];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the activation register is reset as well so a discarded
    // inference leaves no stale vector behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q     <= '0;
            issue_grp <= '0;
            eval_v    <= 1'b0;
            eval_grp  <= '0;
            out_bits  <= '0;
        end else begin
            eval_v   <= w_rd_en;
            eval_grp <= issue_grp;
            if (accept) begin
                act_q     <= in_act;
                issue_grp <= '0;
                out_bits  <= '0;
            end else begin
                out_bits <= bits_nxt;
                if (w_rd_en) issue_grp <= last_issue ? '0 : issue_grp + AW'(1);
            end
        end
    end

`ifdef BNN_FC_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_infer <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready && (perf_infer != 16'hFFFF))
                perf_infer <= perf_infer + 16'd1;
            if ((state == DONE) && !out_ready && (perf_stall != 16'hFFFF))
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bnn_fc_sched.sv
// -----------------------------------------------------------------------------
// tb_bnn_fc_sched
// Directed bench for bnn_fc_sched. Three instances run in lock-step on the
// same stimulus:
//   dut0 : defaults (ISIZE=81, LSIZE=10, PAR=2, THRESHOLD=0)
//   dut1 : THRESHOLD=-1
//   dut2 : LSIZE=9 (partial last group)
// All have NGRP=5, AW=3. Each has its own 1-cycle-latency weight memory
// model reading a shared table.
// -----------------------------------------------------------------------------
module tb_bnn_fc_sched;

    localparam int ISIZE = 81;
    localparam int DW    = 2 * ISIZE;
    localparam logic [ISIZE-1:0] ONES = {ISIZE{1'b1}};
    localparam logic [ISIZE-1:0] ZERO = '0;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [ISIZE-1:0] in_act;
    logic             out_ready;

    logic [DW-1:0] mem_d [5];
    logic [DW-1:0] mem_m [5];

    logic          in_ready0, in_ready1, in_ready2;
    logic          w_rd_en0, w_rd_en1, w_rd_en2;
    logic [2:0]    w_addr0, w_addr1, w_addr2;
    logic [DW-1:0] w_data0, w_data1, w_data2;
    logic [DW-1:0] w_mask0, w_mask1, w_mask2;
    logic          out_valid0, out_valid1, out_valid2;
    logic [9:0]    out_bits0, out_bits1;
    logic [8:0]    out_bits2;
    logic          busy0, busy1, busy2;
`ifdef BNN_FC_PERF_EN
    logic [15:0]   perf_infer0, perf_infer1, perf_infer2;
    logic [15:0]   perf_stall0, perf_stall1, perf_stall2;
`endif

    int checks = 0;
    int errors = 0;

    bnn_fc_sched #(.ISIZE(ISIZE), .LSIZE(10), .PAR(2), .THRESHOLD(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_act(in_act),
        .w_rd_en(w_rd_en0), .w_addr(w_addr0), .w_data(w_data0), .w_mask(w_mask0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_bits(out_bits0),
`ifdef BNN_FC_PERF_EN
        .perf_infer(perf_infer0), .perf_stall(perf_stall0),
`endif
        .busy(busy0)
    );

    bnn_fc_sched #(.ISIZE(ISIZE), .LSIZE(10), .PAR(2), .THRESHOLD(-1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_act(in_act),
        .w_rd_en(w_rd_en1), .w_addr(w_addr1), .w_data(w_data1), .w_mask(w_mask1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_bits(out_bits1),
`ifdef BNN_FC_PERF_EN
        .perf_infer(perf_infer1), .perf_stall(perf_stall1),
`endif
        .busy(busy1)
    );

    bnn_fc_sched #(.ISIZE(ISIZE), .LSIZE(9), .PAR(2), .THRESHOLD(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_act(in_act),
        .w_rd_en(w_rd_en2), .w_addr(w_addr2), .w_data(w_data2), .w_mask(w_mask2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_bits(out_bits2),
`ifdef BNN_FC_PERF_EN
        .perf_infer(perf_infer2), .perf_stall(perf_stall2),
`endif
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // weight memory models, one read port per instance
    always @(posedge clk) begin
        if (w_rd_en0) begin w_data0 <= mem_d[w_addr0]; w_mask0 <= mem_m[w_addr0]; end
        if (w_rd_en1) begin w_data1 <= mem_d[w_addr1]; w_mask1 <= mem_m[w_addr1]; end
        if (w_rd_en2) begin w_data2 <= mem_d[w_addr2]; w_mask2 <= mem_m[w_addr2]; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [ISIZE-1:0] d, input logic [ISIZE-1:0] m);
        for (int g = 0; g < 5; g++) begin
            mem_d[g] = {d, d};
            mem_m[g] = {m, m};
        end
    endtask

    // Accept one vector, measure latency and read count, check all results,
    // then complete the handshake.
    task automatic run_infer(input logic [ISIZE-1:0] act, input logic [9:0] e0,
                             input logic [9:0] e1, input logic [8:0] e2, input string tag);
        int lat;
        int rd;
        in_act   = act;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        rd  = 0;
        while (!out_valid0 && lat < 20) begin
            if (w_rd_en2) rd++;
            step();
            lat++;
        end
        check({tag, " latency"}, lat, 7);
        check({tag, " reads"}, rd, 5);
        check({tag, " bits0"}, out_bits0, e0);
        check({tag, " bits1"}, out_bits1, e1);
        check({tag, " bits2"}, out_bits2, e2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " idle"}, {in_ready0, out_valid0, busy0}, 3'b100);
    endtask

    initial begin
        int wait_cyc;
        in_valid  = 1'b0;
        in_act    = '0;
        out_ready = 1'b0;
        fill(ZERO, ZERO);
        rst = 1'b0;
        step();
        step();

        // reset state
        check("rst outs", {out_valid0, w_rd_en0, w_addr0, busy0}, 6'b0);
        check("rst bits", out_bits0, 10'h000);
        rst = 1'b1;
        step();
        check("rst in_ready", in_ready0, 1'b1);

        // full-vote ones with explicit issue sequence and latency
        fill(ONES, ONES);
        in_act   = ONES;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("run in_ready", {in_ready0, busy0}, 2'b01);
        for (int g = 0; g < 5; g++) begin
            check($sformatf("issue %0d", g), {w_rd_en0, w_addr0}, {1'b1, 3'(g)});
            step();
        end
        check("drain", {w_rd_en0, out_valid0, busy0}, 3'b001);
        step();
        check("done t+7", out_valid0, 1'b1);
        check("ones bits0", out_bits0, 10'h3FF);
        check("ones bits1", out_bits1, 10'h3FF);
        check("ones bits2", out_bits2, 9'h1FF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ones idle", {in_ready0, out_valid0}, 2'b10);

        // anti-match, with out_ready already high before out_valid
        fill(ZERO, ONES);
        out_ready = 1'b1;
        step();
        check("early ready", {out_valid0, busy0}, 2'b00);
        run_infer(ONES, 10'h000, 10'h000, 9'h000, "anti");

        // all-zero mask: bit = 0 > THRESHOLD
        fill(ZERO, ZERO);
        run_infer(ONES, 10'h000, 10'h3FF, 9'h000, "zmask");

        // partial last group: group 4 fully ones, group 0 slice 0 ones
        fill(ZERO, ONES);
        mem_d[0] = {ZERO, ONES};
        mem_d[4] = {ONES, ONES};
        run_infer(ONES, 10'h301, 10'h301, 9'h101, "partial");

        // compare boundaries: 41 vs 40 matches of 81, 6 vs 5 matches of 10
        fill(ZERO, ONES);
        mem_d[0] = {ONES >> 41, ONES >> 40};
        mem_d[1] = {ONES >> 76, ONES >> 75};
        mem_m[1] = {ONES >> 71, ONES >> 71};
        run_infer(ONES, 10'h005, 10'h00D, 9'h005, "edge");

        // backpressure
        fill(ONES, ONES);
        in_act   = ONES;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_cyc = 1;
        while (!out_valid0 && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        check("bp latency", wait_cyc, 7);
        in_act   = ZERO;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp hold %0d", i), {out_valid0, in_ready0, out_bits0}, {2'b10, 10'h3FF});
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp last", {out_valid0, out_bits0}, {1'b1, 10'h3FF});
        step();
        out_ready = 1'b0;
        check("bp release", {in_ready0, out_valid0, busy0}, 3'b100);

        // reset in the middle of RUN
        fill(ONES, ONES);
        in_act   = ONES;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mid addr", {w_rd_en0, w_addr0}, 4'b1010);
        rst = 1'b0;
        #1;
        check("mid reset", {w_rd_en0, out_valid0, busy0}, 3'b000);
        check("mid reset bits", out_bits0, 10'h000);
        step();
        rst = 1'b1;
        step();
        check("post reset idle", {in_ready0, out_valid0}, 2'b10);
        run_infer(ONES, 10'h3FF, 10'h3FF, 9'h1FF, "post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnn_fc_sched.md
Name: bnn_fc_sched

Overview:
- Time-multiplexed scheduler and evaluator for one binarized fully-connected layer (XNOR/popcount/threshold).
- Replaces the fully parallel layer when area matters. Accepts one binary activation vector, streams per-neuron weight and valid-mask words from a 1-cycle-latency weight memory, and evaluates PAR neurons per cycle.
- Returns the LSIZE-bit output vector with a valid/ready handshake.
- Sits between the previous layer's output register and the next layer's input.

Parameters:
- ISIZE, 81, activation vector width (inputs per neuron).
- LSIZE, 10, number of neurons (output bits).
- PAR, 2, neurons evaluated per cycle; 1 <= PAR <= LSIZE.
- THRESHOLD, 0, signed integer added to the neuron's valid-weight count before the compare.
- NGRP, derived = ceil(LSIZE/PAR), number of weight words per inference.
- AW, derived = max(1, $clog2(NGRP)), weight address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  activation vector offered.
- in_ready  out  1  block can accept an activation vector.
- in_act  in  ISIZE  binary activations.
- w_rd_en  out  1  weight memory read strobe.
- w_addr  out  AW  weight group index.
- w_data  in  PAR*ISIZE  weights; neuron p of the group occupies slice [p*ISIZE +: ISIZE]. Valid the cycle after w_rd_en.
- w_mask  in  PAR*ISIZE  per-weight valid mask, same layout and timing as w_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_bits  out  LSIZE  neuron outputs; bit n = neuron n.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; activation register, out_bits and group counters cleared.
  - in_ready=1 after reset release; out_valid=0, w_rd_en=0, w_addr=0, busy=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (cycle t): latch in_act, clear out_bits, go to RUN.
- RUN:
  - Cycles t+1 .. t+NGRP: w_rd_en=1, w_addr = 0,1,..,NGRP-1 (one per cycle, no gaps).
  - After the issue of address NGRP-1, go to DRAIN.
- Evaluate stage:
  - The data for address g returns one cycle after issue. On that edge, write neuron bits g*PAR+p for each p.
  - Write only when g*PAR+p < LSIZE; slices beyond LSIZE in the last group are ignored.
- DRAIN:
  - One cycle, w_rd_en=0; the last group is evaluated on this edge.
  - Then go to DONE.
- DONE:
  - out_valid=1 from cycle t+NGRP+2.
  - out_bits stay stable until out_valid&&out_ready, then return to IDLE.
  - in_ready=0 in every state except IDLE, so there is no overlap between inferences.
- Neuron arithmetic:
  - x = ~(act ^ w) & mask.
  - cnt = popcount(x); nv = popcount(mask).
  - bit = (2*cnt) > (THRESHOLD + nv), evaluated as a signed compare.
  - Width is $clog2(ISIZE+1)+2 signed bits, which is sufficient for negative THRESHOLD.
- Boundary conditions:
  - All-zero mask: cnt=nv=0, so bit = (0 > THRESHOLD).
  - NGRP=1: RUN lasts exactly one cycle.
  - in_valid while busy: ignored and held by the producer.
  - out_ready high before out_valid: no effect.
  - Reset mid-RUN/DRAIN/DONE: result is discarded, no out_valid pulse, and the weight read stops immediately.

Optional Feature:
- Macro: BNN_FC_PERF_EN.
- Defined:
  - Adds output perf_infer (16 bits), a saturating count of completed handshakes (out_valid&&out_ready). Holds at 16'hFFFF.
  - Adds output perf_stall (16 bits), a saturating count of cycles in DONE with out_ready=0.
  - Both are cleared by reset.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package bnn_fc_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Function ceil_div.
  - Function pop_w(isize) giving the signed popcount width.
- Sub-module bnn_neuron_eval:
  - Combinational XNOR, mask, popcount and threshold compare for one neuron.
  - Parameters ISIZE and THRESHOLD.
  - Instantiated PAR times in the evaluate stage.

Test Plan:
- Latency and full-vote ones, default params (NGRP=5): in_act all-ones, w_data all-ones, mask all-ones, accept at t.
  - w_addr sequence 0..4 on t+1..t+5.
  - out_valid at t+7, out_bits=10'h3FF (162 > 81).
- Anti-match: in_act all-ones, w_data all-zeros, mask all-ones -> out_bits=10'h000 (0 > 81 false).
- Zero mask and threshold: mask all-zeros with THRESHOLD=0 -> 10'h000. With THRESHOLD=-1 -> 10'h3FF.
- Partial last group: LSIZE=9, PAR=2 (NGRP=5).
  - w_data slice 1 of group 4 all-ones with act all-ones.
  - out_bits is 9 bits and is unaffected by the unused slice.
  - 5 reads are issued.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - out_bits stable, in_ready=0, a held in_valid is not accepted.
  - The handshake completes in the first cycle out_ready=1, and in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst=0 at w_addr=2.
  - Immediately w_rd_en=0, out_valid=0, busy=0.
  - After release a fresh inference completes correctly with latency NGRP+2.
